// File: rtl/bus_arbiter_pkg.sv
// Shared types and defaults for the ibus/dbus memory-port arbiter.
package bus_arbiter_pkg;

    localparam int ARB_ADDR_W       = 64;
    localparam int ARB_DATA_W       = 64;
    localparam int STARVE_LIMIT_DEF = 4;

    // Bit positions inside the two-bit grant / exclude vectors.
    localparam int GNT_I = 0;
    localparam int GNT_D = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [ARB_ADDR_W-1:0]   addr;
        logic [ARB_DATA_W/8-1:0] strobe;
        logic [ARB_DATA_W-1:0]   wdata;
    } arb_req_t;

endpackage

// File: rtl/bus_arbiter_arb_pick.sv
// Combinational priority pick: dbus first unless ibus has waited STARVE_LIMIT dbus grants.
module bus_arbiter_arb_pick
    import bus_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int CNT_W        = $clog2(STARVE_LIMIT + 1)
) (
    input  logic             i_valid,
    input  logic             d_valid,
    input  logic [CNT_W-1:0] starve_cnt,
    input  logic [1:0]       excl,
    output logic [1:0]       grant
);

    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

    logic i_ok;
    logic d_ok;

    // A requester that just completed still holds valid this cycle, so it is masked out.
    assign i_ok = i_valid & ~excl[GNT_I];
    assign d_ok = d_valid & ~excl[GNT_D];

    always_comb begin
        grant = '0;
        if (d_ok && (!i_ok || (starve_cnt < LIMIT_C))) begin
            grant[GNT_D] = 1'b1;
        end else if (i_ok) begin
            grant[GNT_I] = 1'b1;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Shares one memory port between ibus and dbus; latches the granted request until m_data_ok.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int ADDR_W       = ARB_ADDR_W,
    parameter int DATA_W       = ARB_DATA_W,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_valid,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_data_ok,
    output logic [31:0]         i_data,
    input  logic                d_valid,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W/8-1:0] d_strobe,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_data_ok,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                m_valid,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W/8-1:0] m_strobe,
    output logic [DATA_W-1:0]   m_wdata,
    input  logic                m_data_ok,
    input  logic [DATA_W-1:0]   m_rdata
);

    localparam int               CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

    arb_state_t       state_q, state_d;
    arb_req_t         req_q, req_d;
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic             arb_en;
    logic [1:0]       excl;
    logic [1:0]       grant;

    bus_arbiter_arb_pick #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CNT_W        (CNT_W)
    ) u_pick (
        .i_valid    (i_valid),
        .d_valid    (d_valid),
        .starve_cnt (starve_cnt_q),
        .excl       (excl),
        .grant      (grant)
    );

    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        starve_cnt_d = starve_cnt_q;
        arb_en       = 1'b0;
        excl         = 2'b00;
        i_data_ok    = 1'b0;
        d_data_ok    = 1'b0;

        unique case (state_q)
            IDLE: arb_en = 1'b1;
            BUSY_I: begin
                if (m_data_ok) begin
                    i_data_ok   = 1'b1;
                    arb_en      = 1'b1;
                    excl[GNT_I] = 1'b1;
                end
            end
            BUSY_D: begin
                if (m_data_ok) begin
                    d_data_ok   = 1'b1;
                    arb_en      = 1'b1;
                    excl[GNT_D] = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (arb_en) begin
            if (grant[GNT_D]) begin
                state_d      = BUSY_D;
                req_d.addr   = d_addr;
                req_d.strobe = d_strobe;
                req_d.wdata  = d_wdata;
                if (i_valid && (starve_cnt_q != LIMIT_C)) begin
                    starve_cnt_d = starve_cnt_q + 1'b1;
                end
            end else if (grant[GNT_I]) begin
                state_d      = BUSY_I;
                req_d.addr   = i_addr;
                req_d.strobe = '0;
                req_d.wdata  = '0;
                starve_cnt_d = '0;
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            req_q        <= '0;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign m_valid  = (state_q != IDLE);
    assign m_addr   = req_q.addr;
    assign m_strobe = req_q.strobe;
    assign m_wdata  = req_q.wdata;

    // Fetches are 32-bit; address bit 2 selects the word within the 64-bit beat.
    assign i_data  = req_q.addr[2] ? m_rdata[63:32] : m_rdata[31:0];
    assign d_rdata = m_rdata;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: stimulus pushes expected grants/responses, a negedge monitor checks them.
module tb_bus_arbiter;
    import bus_arbiter_pkg::*;

    typedef struct {
        logic [63:0] addr;
        logic [7:0]  strobe;
        logic [63:0] wdata;
    } grant_t;

    typedef struct {
        bit          is_d;
        logic [63:0] data;
    } resp_t;

    logic        clk;
    logic        reset;
    logic        i_valid;
    logic [63:0] i_addr;
    logic        i_data_ok;
    logic [31:0] i_data;
    logic        d_valid;
    logic [63:0] d_addr;
    logic [7:0]  d_strobe;
    logic [63:0] d_wdata;
    logic        d_data_ok;
    logic [63:0] d_rdata;
    logic        m_valid;
    logic [63:0] m_addr;
    logic [7:0]  m_strobe;
    logic [63:0] m_wdata;
    logic        m_data_ok;
    logic [63:0] m_rdata;

    int tests = 0;
    int fails = 0;

    grant_t gq[$];
    resp_t  rq[$];
    grant_t mg;
    resp_t  mr;
    logic   prev_mvalid = 1'b0;
    logic   prev_done   = 1'b0;

    bus_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .i_valid   (i_valid),
        .i_addr    (i_addr),
        .i_data_ok (i_data_ok),
        .i_data    (i_data),
        .d_valid   (d_valid),
        .d_addr    (d_addr),
        .d_strobe  (d_strobe),
        .d_wdata   (d_wdata),
        .d_data_ok (d_data_ok),
        .d_rdata   (d_rdata),
        .m_valid   (m_valid),
        .m_addr    (m_addr),
        .m_strobe  (m_strobe),
        .m_wdata   (m_wdata),
        .m_data_ok (m_data_ok),
        .m_rdata   (m_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_grant(input logic [63:0] a, input logic [7:0] s, input logic [63:0] w);
        grant_t g;
        g.addr = a; g.strobe = s; g.wdata = w;
        gq.push_back(g);
    endtask

    task automatic push_resp(input bit is_d, input logic [63:0] data);
        resp_t r;
        r.is_d = is_d; r.data = data;
        rq.push_back(r);
    endtask

    // Monitor: a new grant is m_valid after an idle cycle or right after a completion.
    always @(negedge clk) begin
        if (reset) begin
            if (m_valid && (!prev_mvalid || prev_done)) begin
                check("grant_expected", 64'(gq.size() != 0), 64'd1);
                if (gq.size() != 0) begin
                    mg = gq.pop_front();
                    $display("[TB] grant addr=%h strobe=%h wdata=%h", m_addr, m_strobe, m_wdata);
                    check("grant_addr", m_addr, mg.addr);
                    check("grant_strobe", 64'(m_strobe), 64'(mg.strobe));
                    check("grant_wdata", m_wdata, mg.wdata);
                end
            end
            if (i_data_ok || d_data_ok) begin
                check("resp_expected", 64'(rq.size() != 0), 64'd1);
                if (rq.size() != 0) begin
                    mr = rq.pop_front();
                    $display("[TB] resp i_ok=%0d d_ok=%0d i_data=%h d_rdata=%h",
                             i_data_ok, d_data_ok, i_data, d_rdata);
                    check("resp_owner", 64'({i_data_ok, d_data_ok}), mr.is_d ? 64'd1 : 64'd2);
                    check("resp_data", mr.is_d ? d_rdata : 64'(i_data), mr.data);
                end
            end
        end else begin
            check("resp_in_reset", 64'({i_data_ok, d_data_ok}), 64'd0);
        end
        prev_mvalid = m_valid;
        prev_done   = i_data_ok | d_data_ok;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; i_valid = 1'b0; i_addr = '0; d_valid = 1'b0; d_addr = '0;
        d_strobe = '0; d_wdata = '0; m_data_ok = 1'b0; m_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_i_data_ok", 64'(i_data_ok), 64'd0);
        check("rst_d_data_ok", 64'(d_data_ok), 64'd0);
        check("rst_m_addr", m_addr, 64'd0);
        check("rst_starve", 64'(dut.starve_cnt_q), 64'd0);
        tick();
        reset = 1'b1;

        // Lone ibus fetch from the upper word.
        tick();
        i_valid = 1'b1; i_addr = 64'h8000_0004;
        push_grant(64'h8000_0004, 8'h00, 64'd0);
        @(negedge clk);
        check("lone_c0_m_valid", 64'(m_valid), 64'd0);
        tick();
        @(negedge clk);
        check("lone_c1_m_valid", 64'(m_valid), 64'd1);
        tick();
        tick();
        m_data_ok = 1'b1; m_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
        push_resp(1'b0, 64'h0000_0000_AAAA_BBBB);
        tick();
        m_data_ok = 1'b0; i_valid = 1'b0;
        @(negedge clk);
        check("lone_back_idle", 64'(m_valid), 64'd0);

        // Collision: D first, then I back-to-back with no idle bubble.
        tick();
        i_valid = 1'b1; i_addr = 64'h40;
        d_valid = 1'b1; d_addr = 64'h100; d_strobe = 8'hFF; d_wdata = 64'h1122_3344_5566_7788;
        push_grant(64'h100, 8'hFF, 64'h1122_3344_5566_7788);
        push_grant(64'h40, 8'h00, 64'd0);
        tick();
        tick();
        m_data_ok = 1'b1; m_rdata = 64'h0123_4567_89AB_CDEF;
        push_resp(1'b1, 64'h0123_4567_89AB_CDEF);
        tick();
        m_data_ok = 1'b0; d_valid = 1'b0;
        @(negedge clk);
        check("b2b_m_valid", 64'(m_valid), 64'd1);
        check("b2b_state_i", 64'(dut.state_q), 64'(BUSY_I));
        check("b2b_starve_clr", 64'(dut.starve_cnt_q), 64'd0);
        tick();
        m_data_ok = 1'b1; m_rdata = 64'hFFFF_0000_5555_6666;
        push_resp(1'b0, 64'h0000_0000_5555_6666);
        tick();
        m_data_ok = 1'b0; i_valid = 1'b0;

        // Starvation: four D grants while ibus waits, then I. The ibus drops valid
        // only in each D completion cycle so the back-to-back path does not grant it early.
        for (int k = 0; k < 4; k++) begin
            i_valid = 1'b1; i_addr = 64'h2004;
            d_valid = 1'b1; d_addr = 64'h200 + 64'(8 * k); d_strobe = 8'hFF; d_wdata = 64'(k);
            push_grant(64'h200 + 64'(8 * k), 8'hFF, 64'(k));
            tick();
            @(negedge clk);
            check("starve_count", 64'(dut.starve_cnt_q), 64'(k + 1));
            tick();
            m_data_ok = 1'b1; m_rdata = 64'(100 + k); i_valid = 1'b0;
            push_resp(1'b1, 64'(100 + k));
            tick();
            m_data_ok = 1'b0;
        end
        i_valid = 1'b1; i_addr = 64'h2004; d_addr = 64'h240;
        push_grant(64'h2004, 8'h00, 64'd0);
        @(negedge clk);
        check("starve_at_limit", 64'(dut.starve_cnt_q), 64'd4);
        tick();
        @(negedge clk);
        check("starve_after_i", 64'(dut.starve_cnt_q), 64'd0);
        tick();
        m_data_ok = 1'b1; m_rdata = 64'h1234_5678_9ABC_DEF0; d_valid = 1'b0;
        push_resp(1'b0, 64'h0000_0000_1234_5678);
        tick();
        m_data_ok = 1'b0; i_valid = 1'b0;

        // Stability: request fields changing mid-transaction are ignored.
        i_valid = 1'b1; i_addr = 64'h1000;
        push_grant(64'h1000, 8'h00, 64'd0);
        tick();
        i_addr = 64'h2000;
        @(negedge clk);
        check("stable_addr_1", m_addr, 64'h1000);
        tick();
        @(negedge clk);
        check("stable_addr_2", m_addr, 64'h1000);
        tick();
        m_data_ok = 1'b1; m_rdata = 64'hCAFE_F00D_0BAD_BEEF;
        push_resp(1'b0, 64'h0000_0000_0BAD_BEEF);
        tick();
        m_data_ok = 1'b0; i_valid = 1'b0;
        @(negedge clk);
        check("stable_idle", 64'(m_valid), 64'd0);

        // Spurious response in IDLE, then async reset mid-BUSY_D.
        tick();
        m_data_ok = 1'b1; m_rdata = 64'h5A5A_5A5A_5A5A_5A5A;
        @(negedge clk);
        check("spur_i_ok", 64'(i_data_ok), 64'd0);
        check("spur_d_ok", 64'(d_data_ok), 64'd0);
        tick();
        m_data_ok = 1'b0;
        d_valid = 1'b1; d_addr = 64'h300; d_strobe = 8'h0F; d_wdata = 64'hDEAD;
        push_grant(64'h300, 8'h0F, 64'hDEAD);
        tick();
        @(negedge clk);
        #1 reset = 1'b0;
        #1;
        check("async_rst_m_valid", 64'(m_valid), 64'd0);
        check("async_rst_state", 64'(dut.state_q), 64'(IDLE));
        d_valid = 1'b0;
        tick();
        m_data_ok = 1'b1;
        @(negedge clk);
        check("late_ok_in_rst", 64'(d_data_ok), 64'd0);
        tick();
        reset = 1'b1;
        @(negedge clk);
        check("late_ok_after_rst", 64'(d_data_ok), 64'd0);
        check("late_ok_m_valid", 64'(m_valid), 64'd0);
        tick();
        m_data_ok = 1'b0;
        tick();

        check("grant_queue_empty", 64'(gq.size()), 64'd0);
        check("resp_queue_empty", 64'(rq.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
